// File: rtl/fetch_unit_if.sv
// fetch_unit_if: program-memory bus plus decoder/sequencer handshake
// master = fetch_unit, slave = memory/sequencer side
interface fetch_unit_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] mem_addr;
  logic            mem_req;
  logic            mem_ack;
  logic [7:0]      mem_data;
  logic [7:0]      instruction;
  logic            instr_valid;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            halt;
  logic            halted;

  modport master (
    output mem_addr, mem_req,
    output instruction, instr_valid,
    output pc, pc_next, halted,
    input  mem_ack, mem_data,
    input  instr_ready,
    input  branch_taken, branch_target,
    input  halt
  );

  modport slave (
    input  mem_addr, mem_req,
    input  instruction, instr_valid,
    input  pc, pc_next, halted,
    output mem_ack, mem_data,
    output instr_ready,
    output branch_taken, branch_target,
    output halt
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, memory req/ack fetch, instruction register
// Optional single-entry prefetch buffer: define FETCH_PREFETCH_EN
module fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] faddr_q, faddr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;

  logic            req;
  logic [PC_W-1:0] addr;
  logic            consume;
  logic [PC_W-1:0] pc_inc;

`ifdef FETCH_PREFETCH_EN
  logic            buf_v_q, buf_v_d;
  logic [7:0]      buf_data_q, buf_data_d;
  logic [PC_W-1:0] buf_addr_q, buf_addr_d;
  // drain: a dropped request still waiting for its ack
  logic            drain_q, drain_d;
  logic [PC_W-1:0] drain_addr_q, drain_addr_d;
  logic            pf_req;
  logic            pf_ack;
`endif

  assign consume = valid_q & bus.instr_ready;
  assign pc_inc  = pc_q + PC_W'(1);

  // next-state, datapath and memory request generation
  always_comb begin
    state_d  = state_q;
    faddr_d  = faddr_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    req      = 1'b0;
    addr     = faddr_q;
`ifdef FETCH_PREFETCH_EN
    buf_v_d      = buf_v_q;
    buf_data_d   = buf_data_q;
    buf_addr_d   = buf_addr_q;
    drain_d      = drain_q;
    drain_addr_d = drain_addr_q;
    pf_req       = 1'b0;
    pf_ack       = 1'b0;
`endif
    unique case (state_q)
      FETCH: begin
        req = 1'b1;
`ifdef FETCH_PREFETCH_EN
        if (drain_q) begin
          addr = drain_addr_q;
          if (bus.mem_ack) drain_d = 1'b0;
        end else
`endif
        if (bus.mem_ack) begin
          instr_d = bus.mem_data;
          pc_d    = faddr_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
`ifdef FETCH_PREFETCH_EN
        pf_req = ~buf_v_q;
        pf_ack = pf_req & bus.mem_ack;
        req    = pf_req;
        addr   = pc_inc;
        if (consume) begin
          if (bus.halt || bus.branch_taken) begin
            buf_v_d      = 1'b0;
            drain_d      = pf_req & ~bus.mem_ack;
            drain_addr_d = pc_inc;
            valid_d      = 1'b0;
            if (bus.halt) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              faddr_d = bus.branch_target;
              state_d = FETCH;
            end
          end else if (buf_v_q) begin
            instr_d = buf_data_q;
            pc_d    = buf_addr_q;
            buf_v_d = 1'b0;
          end else if (pf_ack) begin
            instr_d = bus.mem_data;
            pc_d    = pc_inc;
          end else begin
            faddr_d = pc_inc;
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end else if (pf_ack) begin
          buf_v_d    = 1'b1;
          buf_data_d = bus.mem_data;
          buf_addr_d = pc_inc;
        end
`else
        if (consume) begin
          valid_d = 1'b0;
          if (bus.halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else if (bus.branch_taken) begin
            faddr_d = bus.branch_target;
            state_d = FETCH;
          end else begin
            faddr_d = pc_inc;
            state_d = FETCH;
          end
        end
`endif
      end
      HALTED: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
`ifdef FETCH_PREFETCH_EN
        req  = drain_q;
        addr = drain_addr_q;
        if (drain_q && bus.mem_ack) drain_d = 1'b0;
`endif
      end
      default: state_d = FETCH;
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      faddr_q  <= RESET_PC;
      pc_q     <= RESET_PC;
      instr_q  <= 8'h00;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      faddr_q  <= faddr_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_PREFETCH_EN
  // prefetch buffer and drain tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_v_q      <= 1'b0;
      buf_data_q   <= 8'h00;
      buf_addr_q   <= RESET_PC;
      drain_q      <= 1'b0;
      drain_addr_q <= RESET_PC;
    end else begin
      buf_v_q      <= buf_v_d;
      buf_data_q   <= buf_data_d;
      buf_addr_q   <= buf_addr_d;
      drain_q      <= drain_d;
      drain_addr_q <= drain_addr_d;
    end
  end
`endif

  // reset abandons any request in the same cycle
  assign bus.mem_req     = req & ~reset;
  assign bus.mem_addr    = addr;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_next     = pc_inc;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit (default build)
// memory model returns mem[a] = a + 8'h10
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  fetch_unit_if #(.PC_W(8)) bus ();

  fetch_unit #(
    .PC_W(8),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = bus.mem_addr + 8'h10;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset            = 1'b1;
    bus.mem_ack       = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    bus.halt          = 1'b0;
    step();
    chk("rst_req", 16'(bus.mem_req), 16'h0);
    chk("rst_valid", 16'(bus.instr_valid), 16'h0);
    chk("rst_halted", 16'(bus.halted), 16'h0);
    chk("rst_instr", 16'(bus.instruction), 16'h00);
    chk("rst_pc", 16'(bus.pc), 16'h00);

    reset           = 1'b0;
    bus.mem_ack     = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("str_req", 16'(bus.mem_req), 16'h1);
      chk("str_addr", 16'(bus.mem_addr), 16'(i));
      chk("str_nv", 16'(bus.instr_valid), 16'h0);
      step();
      chk("str_valid", 16'(bus.instr_valid), 16'h1);
      chk("str_instr", 16'(bus.instruction), 16'(i + 16'h10));
      chk("str_pc", 16'(bus.pc), 16'(i));
      chk("str_pcn", 16'(bus.pc_next), 16'(i + 1));
      chk("str_req0", 16'(bus.mem_req), 16'h0);
      step();
    end

    step();
    chk("br_pc", 16'(bus.pc), 16'h03);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h40;
    step();
    chk("br_addr", 16'(bus.mem_addr), 16'h40);
    chk("br_req", 16'(bus.mem_req), 16'h1);
    chk("br_nv", 16'(bus.instr_valid), 16'h0);
    bus.branch_taken = 1'b0;
    step();
    chk("br_pc40", 16'(bus.pc), 16'h40);
    chk("br_pcn", 16'(bus.pc_next), 16'h41);
    chk("br_instr", 16'(bus.instruction), 16'h50);

    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h80;
    step();
    step();
    chk("hold_v", 16'(bus.instr_valid), 16'h1);
    chk("hold_pc", 16'(bus.pc), 16'h40);
    chk("hold_req", 16'(bus.mem_req), 16'h0);
    bus.branch_taken = 1'b0;
    bus.instr_ready  = 1'b1;
    step();
    chk("seq_addr", 16'(bus.mem_addr), 16'h41);
    step();
    chk("seq_pc", 16'(bus.pc), 16'h41);

    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h05;
    bus.mem_ack       = 1'b0;
    step();
    bus.branch_taken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("dly_req", 16'(bus.mem_req), 16'h1);
      chk("dly_addr", 16'(bus.mem_addr), 16'h05);
      chk("dly_nv", 16'(bus.instr_valid), 16'h0);
      step();
    end
    bus.mem_ack = 1'b1;
    chk("dly_addr_ack", 16'(bus.mem_addr), 16'h05);
    step();
    chk("dly_valid", 16'(bus.instr_valid), 16'h1);
    chk("dly_instr", 16'(bus.instruction), 16'h15);
    chk("dly_pc", 16'(bus.pc), 16'h05);

    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'hFE;
    step();
    bus.branch_taken = 1'b0;
    step();
    chk("wr_pcFE", 16'(bus.pc), 16'hFE);
    chk("wr_instrFE", 16'(bus.instruction), 16'h0E);
    chk("wr_pcnFE", 16'(bus.pc_next), 16'hFF);
    step();
    step();
    chk("wr_pcFF", 16'(bus.pc), 16'hFF);
    chk("wr_instrFF", 16'(bus.instruction), 16'h0F);
    chk("wr_pcnFF", 16'(bus.pc_next), 16'h00);
    step();
    chk("wr_addr00", 16'(bus.mem_addr), 16'h00);
    step();
    chk("wr_pc00", 16'(bus.pc), 16'h00);
    chk("wr_instr00", 16'(bus.instruction), 16'h10);

    bus.halt          = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h40;
    step();
    bus.halt         = 1'b0;
    bus.branch_taken = 1'b0;
    chk("hlt_halted", 16'(bus.halted), 16'h1);
    chk("hlt_req", 16'(bus.mem_req), 16'h0);
    chk("hlt_nv", 16'(bus.instr_valid), 16'h0);
    step();
    step();
    chk("hlt_stay", 16'(bus.halted), 16'h1);
    chk("hlt_req2", 16'(bus.mem_req), 16'h0);
    reset = 1'b1;
    step();
    chk("hrst_halted", 16'(bus.halted), 16'h0);
    chk("hrst_req", 16'(bus.mem_req), 16'h0);
    reset = 1'b0;
    #1;
    chk("hrst_req1", 16'(bus.mem_req), 16'h1);
    chk("hrst_addr", 16'(bus.mem_addr), 16'h00);

    step();
    bus.branch_taken  = 1'b1;
    bus.branch_target = 8'h22;
    bus.mem_ack       = 1'b0;
    step();
    bus.branch_taken = 1'b0;
    chk("mid_addr", 16'(bus.mem_addr), 16'h22);
    step();
    reset = 1'b1;
    step();
    chk("mid_req0", 16'(bus.mem_req), 16'h0);
    chk("mid_nv", 16'(bus.instr_valid), 16'h0);
    reset = 1'b0;
    #1;
    chk("mid_addr0", 16'(bus.mem_addr), 16'h00);
    chk("mid_req1", 16'(bus.mem_req), 16'h1);
    bus.mem_ack = 1'b1;
    step();
    chk("mid_instr", 16'(bus.instruction), 16'h10);
    chk("mid_pc", 16'(bus.pc), 16'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
